regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a pending-write scoreboard. It succeeds the single-write, dual-read register file. It adds configurable read and write port counts, a hardwired zero register, asynchronous reset of contents, and per-register busy tracking so that issue logic can detect RAW hazards. It sits between decode/issue (read ports, busy set) and writeback (write ports, busy clear) in the core pipeline.

## Interface
- `REG_COUNT`, default 32: number of architectural registers.
- `DATA_WIDTH`, default 64: register width.
- `ADDR_WIDTH`, default $clog2(REG_COUNT): register index width.
- `NUM_RPORTS`, default 2: read ports, range 1..4.
- `NUM_WPORTS`, default 1: write ports, range 1..2.
- `ZERO_REG`, default 1: when 1, register 0 is hardwired to zero.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `wen` input NUM_WPORTS: per-port write enable.
- `waddr` input NUM_WPORTS*ADDR_WIDTH: packed write indices; port p is at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- `wdata` input NUM_WPORTS*DATA_WIDTH: packed write data.
- `ren` input 1: global read enable.
- `raddr` input NUM_RPORTS*ADDR_WIDTH: packed read indices.
- `rdata` output NUM_RPORTS*DATA_WIDTH: packed read data.
- `rbusy` output NUM_RPORTS: the register addressed by each read port has a pending write.
- `set_en` input 1: mark `set_addr` busy (instruction issued with a destination register).
- `set_addr` input ADDR_WIDTH: destination index to mark.
- `flush` input 1: clear all busy bits (pipeline flush).

## Operation
- Storage is REG_COUNT x DATA_WIDTH flops. Busy is REG_COUNT bits.
- **Write:** on the rising edge, each port with `wen[p]`=1 writes `wdata[p]` to `rf[waddr[p]]`.
  - If two ports target the same index, the higher port index wins.
  - `waddr` >= REG_COUNT is ignored.
- **Zero register:** when ZERO_REG=1:
  - Writes to index 0 are dropped.
  - Reads of index 0 return 0.
  - busy[0] is never set, and `rbusy` for index 0 is 0.
- **Read:** combinational.
  - `rdata[r]` = `ren` ? value : 0.
  - `rbusy[r]` = `ren` ? busy[raddr[r]] (after bypass, see Configuration) : 0.
  - Out-of-range `raddr` reads 0 and reports not busy.
- **Busy update, each edge, in priority order:**
  - `flush`=1: all busy bits are cleared; `set_en` in the same cycle is also ignored.
  - Otherwise, for each port with `wen[p]`=1, busy[waddr[p]] is cleared.
  - Then, if `set_en`=1, busy[set_addr] is set. Set wins over a same-cycle clear to the same index, because the new producer supersedes the retiring one.
- Setting an index that is already busy leaves it busy. No counting is done; one outstanding producer per register is a system guarantee.

## Timing
- **Reset:** while `rst_n`=0, all rf entries are 0 and all busy bits are 0, asynchronously. `rdata` = 0 and `rbusy` = 0 for all ports. Reset asserted mid-operation discards any write on that edge.
- **Write latency:** 1 cycle. The data is visible on a read without bypass in the cycle after `wen`.
- **Busy set latency:** 1 cycle. `rbusy` rises the cycle after `set_en`.
- **Busy clear latency:** 1 cycle without bypass; 0 cycles with bypass.
- There is no handshake. All inputs are sampled every edge.

## Configuration
- **`REGFILE_BYPASS_EN` defined:** write-to-read forwarding is enabled.
  - If any `wen[p]` targets `raddr[r]` in the current cycle, `rdata[r]` returns that `wdata[p]`, using the highest port on conflict.
  - `rbusy[r]` reads 0 unless `set_en`/`set_addr` is also busy-marking that index in the same cycle.
  - The zero register and out-of-range rules still apply.
- **`REGFILE_BYPASS_EN` undefined:** reads return stored flop contents only. `rbusy` reflects the registered busy bits only.

## Test plan
- **Reset:** write `x5`=0xDEAD, then pulse `rst_n` low mid-cycle -> `rdata` for `x5` is 0 immediately; all `rbusy`=0.
- **Zero register:** `wen[0]`=1, `waddr`=0, `wdata`=0x1234; `set_en`=1, `set_addr`=0 -> the read of `x0` is 0 and `rbusy`=0 on all following cycles.
- **Dual write conflict** (NUM_WPORTS=2): both ports write `x7` with 0xAA and 0xBB -> next cycle `x7` reads 0xBB.
- **Bypass:** write `x3`=0x55 while reading `x3`.
  - With `REGFILE_BYPASS_EN`: `rdata`=0x55 in the same cycle.
  - Without it: `rdata` shows the old value, then 0x55 on the next cycle.
- **Scoreboard:** `set_en` on `x9`, then `rbusy`=1 on a read of `x9` for 3 cycles.
  - Write `x9` together with `set_en` on `x9` -> `rbusy` stays 1.
  - Write `x9` alone -> `rbusy` is 0 one cycle later (same cycle with bypass).
- **Flush:** set busy on `x1`, `x2`, `x4`, then `flush`=1 with `set_en` on `x6` -> next cycle all `rbusy`=0, including `x6`.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a pending-write busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes and busy clears to reads.
module regfile_mp #(
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int unsigned NUM_RPORTS = 2,
  parameter int unsigned NUM_WPORTS = 1,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_WPORTS-1:0]            wen,
  input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata,
  input  logic                             ren,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RPORTS-1:0]            rbusy,
  input  logic                             set_en,
  input  logic [ADDR_WIDTH-1:0]            set_addr,
  input  logic                             flush
);

  localparam bit ZR = (ZERO_REG != 0);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  data_t                rf_q [REG_COUNT];
  data_t                rf_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;

  addr_t wa [NUM_WPORTS];
  data_t wd [NUM_WPORTS];
  addr_t ra [NUM_RPORTS];

  // In range and not the hardwired zero register.
  function automatic logic live(input addr_t a);
    return (32'(a) < REG_COUNT) && !(ZR && (a == '0));
  endfunction

  always_comb begin
    for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
      wa[p] = waddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      wd[p] = wdata[p*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int unsigned r = 0; r < NUM_RPORTS; r++) begin
      ra[r] = raddr[r*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Ascending port order lets the highest port win a collision.
  always_comb begin
    rf_d = rf_q;
    for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
      if (wen[p] && live(wa[p])) begin
        rf_d[wa[p]] = wd[p];
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
        if (wen[p] && live(wa[p])) begin
          busy_d[wa[p]] = 1'b0;
        end
      end
      if (set_en && live(set_addr)) begin
        busy_d[set_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q   <= '{default: '0};
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned r = 0; r < NUM_RPORTS; r++) begin
      if (ren && live(ra[r])) begin
        rdata[r*DATA_WIDTH +: DATA_WIDTH] = rf_q[ra[r]];
        rbusy[r] = busy_q[ra[r]];
`ifdef REGFILE_BYPASS_EN
        for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
          if (wen[p] && (wa[p] == ra[r])) begin
            rdata[r*DATA_WIDTH +: DATA_WIDTH] = wd[p];
            rbusy[r] = set_en && !flush && (set_addr == ra[r]);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table plus hand sequences for regfile_mp
// (2 read ports, 2 write ports, 32 x 64, zero register on).
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   wen;
  logic [9:0]   waddr;
  logic [127:0] wdata;
  logic         ren;
  logic [9:0]   raddr;
  logic [127:0] rdata;
  logic [1:0]   rbusy;
  logic         set_en;
  logic [4:0]   set_addr;
  logic         flush;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .REG_COUNT (32),
    .DATA_WIDTH(64),
    .NUM_RPORTS(2),
    .NUM_WPORTS(2),
    .ZERO_REG  (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wen     (wen),
    .waddr   (waddr),
    .wdata   (wdata),
    .ren     (ren),
    .raddr   (raddr),
    .rdata   (rdata),
    .rbusy   (rbusy),
    .set_en  (set_en),
    .set_addr(set_addr),
    .flush   (flush)
  );

  typedef struct {
    logic [1:0]  w;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    logic        se;
    logic [4:0]  sa;
    logic        fl;
    logic        re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] e0;
    logic [63:0] e1;
    logic [1:0]  eb;
  } vec_t;

  function automatic vec_t mk(
    input logic [1:0] w, input logic [4:0] wa0, input logic [63:0] wd0,
    input logic [4:0] wa1, input logic [63:0] wd1,
    input logic se, input logic [4:0] sa, input logic fl, input logic re,
    input logic [4:0] ra0, input logic [4:0] ra1,
    input logic [63:0] e0, input logic [63:0] e1, input logic [1:0] eb);
    vec_t v;
    v.w = w; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.se = se; v.sa = sa; v.fl = fl; v.re = re;
    v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0;
    set_en = 1'b0; set_addr = '0; flush = 1'b0;
    ren = 1'b1;
  endtask

  function automatic logic [63:0] rd(input int r);
    return (r == 0) ? rdata[63:0] : rdata[127:64];
  endfunction

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t vt [11];

  initial begin
    vt[0]  = mk(2'b11, 1, 'h11, 2, 'h22, 0, 0, 0, 1, 3, 4, 0, 0, 2'b00);
    vt[1]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 'h11, 'h22, 2'b00);
    vt[2]  = mk(2'b11, 3, 'h33, 31, ONES, 0, 0, 0, 1, 1, 0, 'h11, 0, 2'b00);
    vt[3]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 3, 31, 'h33, ONES, 2'b00);
    vt[4]  = mk(2'b00, 0, 0, 0, 0, 1, 10, 0, 1, 3, 10, 'h33, 0, 2'b00);
    vt[5]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 10, 3, 0, 'h33, 2'b01);
    vt[6]  = mk(2'b01, 0, 'h1234, 0, 0, 1, 0, 0, 1, 10, 31, 0, ONES, 2'b01);
    vt[7]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 10, 0, 0, 2'b10);
    vt[8]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 3, 10, 0, 0, 2'b00);
    vt[9]  = mk(2'b10, 0, 0, 10, 'hABC, 0, 0, 0, 1, 3, 1, 'h33, 'h11, 2'b00);
    vt[10] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 'hABC, 0, 2'b00);

    // Reset state
    idle();
    rst_n = 1'b0;
    raddr = {5'd0, 5'd5};
    #12;
    chk("reset_rd0", rd(0), 0);
    chk("reset_rbusy", 64'(rbusy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vt[i]) begin
      wen      = vt[i].w;
      waddr    = {vt[i].wa1, vt[i].wa0};
      wdata    = {vt[i].wd1, vt[i].wd0};
      set_en   = vt[i].se;
      set_addr = vt[i].sa;
      flush    = vt[i].fl;
      ren      = vt[i].re;
      raddr    = {vt[i].ra1, vt[i].ra0};
      #3;
      chk($sformatf("vec%0d_rd0", i), rd(0), vt[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd(1), vt[i].e1);
      chk($sformatf("vec%0d_rbusy", i), 64'(rbusy), 64'(vt[i].eb));
      tick();
    end
    idle();

    // Dual write to the same index: port 1 wins
    wen = 2'b11; waddr = {5'd7, 5'd7}; wdata = {64'hBB, 64'hAA};
    raddr = {5'd0, 5'd7};
    #3;
    chk("dual_same", rd(0), BYP ? 64'hBB : 64'h0);
    tick();
    idle();
    #3;
    chk("dual_next", rd(0), 64'hBB);

    // Write-to-read forwarding
    wen = 2'b01; waddr = {5'd0, 5'd3}; wdata = {64'h0, 64'h55};
    raddr = {5'd0, 5'd3};
    #3;
    chk("byp_same", rd(0), BYP ? 64'h55 : 64'h33);
    tick();
    idle();
    #3;
    chk("byp_next", rd(0), 64'h55);

    // Scoreboard on x9
    set_en = 1'b1; set_addr = 5'd9; raddr = {5'd0, 5'd9};
    #3;
    chk("sb_set_same", 64'(rbusy[0]), 0);
    tick();
    set_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk($sformatf("sb_hold%0d", c), 64'(rbusy[0]), 1);
      tick();
    end
    wen = 2'b01; waddr = {5'd0, 5'd9}; wdata = {64'h0, 64'h99};
    set_en = 1'b1;
    #3;
    chk("sb_wr_set_same", 64'(rbusy[0]), 1);
    tick();
    idle();
    #3;
    chk("sb_wr_set_next", 64'(rbusy[0]), 1);
    chk("sb_wr_set_data", rd(0), 64'h99);
    wen = 2'b01; waddr = {5'd0, 5'd9}; wdata = {64'h0, 64'h77};
    #3;
    chk("sb_clr_same", 64'(rbusy[0]), BYP ? 64'h0 : 64'h1);
    chk("sb_clr_data", rd(0), BYP ? 64'h77 : 64'h99);
    tick();
    idle();
    #3;
    chk("sb_clr_next", 64'(rbusy[0]), 0);

    // Flush wins over a same-cycle set
    set_en = 1'b1;
    set_addr = 5'd1; tick();
    set_addr = 5'd2; tick();
    set_addr = 5'd4; tick();
    set_en = 1'b0;
    raddr = {5'd2, 5'd1};
    #3;
    chk("fl_pre", 64'(rbusy), 64'h3);
    flush = 1'b1; set_en = 1'b1; set_addr = 5'd6;
    raddr = {5'd6, 5'd4};
    #1;
    chk("fl_same", 64'(rbusy), 64'h1);
    tick();
    idle();
    raddr = {5'd6, 5'd4};
    #3;
    chk("fl_next_x4x6", 64'(rbusy), 0);
    raddr = {5'd2, 5'd1};
    #1;
    chk("fl_next_x1x2", 64'(rbusy), 0);
    tick();

    // Asynchronous reset mid-cycle
    wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {64'h0, 64'hDEAD};
    set_en = 1'b1; set_addr = 5'd5;
    tick();
    idle();
    raddr = {5'd3, 5'd5};
    #3;
    chk("rst_pre_data", rd(0), 64'hDEAD);
    chk("rst_pre_busy", 64'(rbusy), 64'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_rd0", rd(0), 0);
    chk("rst_async_rd1", rd(1), 0);
    chk("rst_async_busy", 64'(rbusy), 0);
    wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {64'h0, 64'h99};
    tick();
    idle();
    raddr = {5'd3, 5'd5};
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst_drop_wr", rd(0), 0);
    chk("rst_clear_x3", rd(1), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
